// File: rtl/vga_pkg.sv
// Shared definitions for the VGA receive path.
// Holds the 640x480@60 timing constants, the error-code enum and the
// receiver FSM state enum.
package vga_pkg;

    // 640x480@60 horizontal timing, in pixel clocks
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FRONT  = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BACK   = 48;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    // 640x480@60 vertical timing, in lines
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FRONT  = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BACK   = 33;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Consecutive clean frames needed before the stream counts as locked
    localparam int VGA_LOCK_FRAMES = 2;

    // CRC-16-CCITT used for the per-frame pixel checksum
    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // Geometry error reported on err_code; a lower code wins when several hit at once
    typedef enum logic [1:0] {
        ERR_NONE      = 2'd0,
        ERR_HS_PERIOD = 2'd1,
        ERR_VS_PERIOD = 2'd2,
        ERR_ACTIVE    = 2'd3
    } err_code_t;

    // Receiver lock state
    typedef enum logic [1:0] {
        RX_SEARCH = 2'd0,
        RX_TRACK  = 2'd1,
        RX_LOCKED = 2'd2
    } rx_state_t;

endpackage

// File: rtl/vga_rx_crc16.sv
// CRC-16-CCITT accumulator, 24 data bits (one RGB pixel) per clock, MSB first.
// Only built when VGA_RX_CRC_EN is defined; otherwise this file is empty.
`ifdef VGA_RX_CRC_EN
module vga_rx_crc16
    import vga_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        en,
    input  logic [23:0] data,
    output logic [15:0] crc_next
);

    // Fold 24 bits into the running CRC, most significant bit first
    function automatic logic [15:0] crc16_step24(input logic [15:0] crc_in, input logic [23:0] d);
        logic [15:0] c;
        c = crc_in;
        for (int i = 23; i >= 0; i--) begin
            if (c[15] ^ d[i])
                c = {c[14:0], 1'b0} ^ CRC_POLY;
            else
                c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    logic [15:0] acc;

    // crc_next already includes this cycle's pixel so a capture on clear loses nothing
    assign crc_next = en ? crc16_step24(acc, data) : acc;

    // Accumulator restarts from the CCITT seed at every frame boundary
    always_ff @(posedge clock) begin
        if (reset || clear)
            acc <= CRC_INIT;
        else
            acc <= crc_next;
    end

endmodule
`endif

// File: rtl/vga_rx.sv
// VGA stream receiver: samples the generator's pins, recovers pixel
// coordinates, checks line/frame/active geometry and tracks lock.
// Optional per-frame CRC of the recovered pixels when VGA_RX_CRC_EN is defined.
module vga_rx
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int H_TOTAL     = VGA_H_TOTAL,
    parameter int V_TOTAL     = VGA_V_TOTAL,
    parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        vga_hs,
    input  logic        vga_vs,
    input  logic        vga_blank_n,
    input  logic [7:0]  vga_r,
    input  logic [7:0]  vga_g,
    input  logic [7:0]  vga_b,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [23:0] pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [15:0] frame_count,
    output logic [15:0] crc,
    output logic        crc_valid
);

    localparam logic [11:0] H_TOTAL_W  = 12'(H_TOTAL);
    localparam logic [10:0] V_TOTAL_W  = 11'(V_TOTAL);
    localparam logic [9:0]  H_ACTIVE_W = 10'(H_ACTIVE);
    localparam logic [10:0] V_ACTIVE_W = 11'(V_ACTIVE);
    localparam logic [7:0]  LOCK_W     = 8'(LOCK_FRAMES);

    logic        s1_hs, s1_vs, s1_blank_n;
    logic [23:0] s1_rgb;
    logic        prev_hs, prev_vs, prev_blank_n;

    // Input stage: every pin is registered once; edges are found against the previous s1 value
    // NOTE: sequential state uses non-blocking (<=) so every register sees pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_hs        <= 1'b0;
            s1_vs        <= 1'b0;
            s1_blank_n   <= 1'b0;
            s1_rgb       <= '0;
            prev_hs      <= 1'b0;
            prev_vs      <= 1'b0;
            prev_blank_n <= 1'b0;
        end else begin
            s1_hs        <= vga_hs;
            s1_vs        <= vga_vs;
            s1_blank_n   <= vga_blank_n;
            s1_rgb       <= {vga_r, vga_g, vga_b};
            prev_hs      <= s1_hs;
            prev_vs      <= s1_vs;
            prev_blank_n <= s1_blank_n;
        end
    end

    logic hs_fall, vs_fall, blank_fall;
    assign hs_fall    = prev_hs & ~s1_hs;
    assign vs_fall    = prev_vs & ~s1_vs;
    assign blank_fall = prev_blank_n & ~s1_blank_n;

    logic [10:0] h_cnt;
    logic [9:0]  v_cnt, x_cnt, y_cnt;
    logic        line_active, h_seen;

    // Lengths as seen at the closing edge; a coincident hs_fall belongs to the ending frame
    logic [11:0] h_len;
    logic [10:0] v_lines, y_lines;
    assign h_len   = {1'b0, h_cnt} + 12'd1;
    assign v_lines = {1'b0, v_cnt} + {10'd0, hs_fall};
    assign y_lines = {1'b0, y_cnt} + {10'd0, hs_fall & line_active};

    // Geometry counters, all saturating; h_seen masks the first hs_fall after reset
    always_ff @(posedge clock) begin
        if (reset) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            x_cnt       <= '0;
            y_cnt       <= '0;
            line_active <= 1'b0;
            h_seen      <= 1'b0;
        end else begin
            if (hs_fall) begin
                h_cnt  <= '0;
                h_seen <= 1'b1;
            end else if (h_cnt != '1) begin
                h_cnt <= h_cnt + 11'd1;
            end

            if (vs_fall)
                v_cnt <= '0;
            else if (hs_fall && v_cnt != '1)
                v_cnt <= v_cnt + 10'd1;

            if (hs_fall)
                x_cnt <= '0;
            else if (s1_blank_n && x_cnt != '1)
                x_cnt <= x_cnt + 10'd1;

            if (vs_fall)
                y_cnt <= '0;
            else if (hs_fall && line_active && y_cnt != '1)
                y_cnt <= y_cnt + 10'd1;

            if (hs_fall)
                line_active <= 1'b0;
            else if (s1_blank_n)
                line_active <= 1'b1;
        end
    end

    rx_state_t state;
    logic [7:0] good;
    logic       frame_err;
    logic       tracking;
    logic       chk_hs, chk_vs, chk_act, err_hit;
    err_code_t  err_now;

    assign tracking = (state != RX_SEARCH);
    assign chk_hs   = tracking & hs_fall & h_seen & (h_len != H_TOTAL_W);
    assign chk_vs   = tracking & vs_fall & (v_lines != V_TOTAL_W);
    assign chk_act  = tracking & ((blank_fall & (x_cnt != H_ACTIVE_W)) |
                                  (vs_fall & (y_lines != V_ACTIVE_W)));

    // Error priority: lowest code wins when several checks fail together
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        err_now = ERR_NONE;
        if (chk_act) err_now = ERR_ACTIVE;
        if (chk_vs)  err_now = ERR_VS_PERIOD;
        if (chk_hs)  err_now = ERR_HS_PERIOD;
    end
    assign err_hit = (err_now != ERR_NONE);

    // Lock FSM plus the registered pixel/status outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= RX_SEARCH;
            good        <= '0;
            frame_err   <= 1'b0;
            locked      <= 1'b0;
            err         <= 1'b0;
            err_code    <= '0;
            frame_count <= '0;
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
        end else begin
            err <= err_hit;
            if (err_hit)
                err_code <= err_now;
            pix_valid   <= tracking & s1_blank_n;
            pix_x       <= x_cnt;
            pix_y       <= y_cnt;
            pix_rgb     <= s1_rgb;
            frame_start <= tracking & s1_blank_n & (x_cnt == '0) & (y_cnt == '0);

            case (state)
                RX_SEARCH: begin
                    if (vs_fall) begin
                        state     <= RX_TRACK;
                        good      <= '0;
                        frame_err <= 1'b0;
                    end
                end
                RX_TRACK: begin
                    if (vs_fall) begin
                        frame_err <= 1'b0;
                        if (frame_err || err_hit) begin
                            good <= '0;
                        end else begin
                            good <= good + 8'd1;
                            if (good + 8'd1 == LOCK_W) begin
                                state       <= RX_LOCKED;
                                locked      <= 1'b1;
                                frame_count <= frame_count + 16'd1;
                            end
                        end
                    end else if (err_hit) begin
                        frame_err <= 1'b1;
                    end
                end
                RX_LOCKED: begin
                    // An errored frame is not counted; the remainder of a frame hit mid-way is tainted
                    if (err_hit) begin
                        state     <= RX_TRACK;
                        locked    <= 1'b0;
                        good      <= '0;
                        frame_err <= ~vs_fall;
                    end else if (vs_fall) begin
                        frame_count <= frame_count + 16'd1;
                    end
                end
                default: state <= RX_SEARCH;
            endcase
        end
    end

`ifdef VGA_RX_CRC_EN
    logic [15:0] crc_next;

    vga_rx_crc16 u_crc (
        .clock    (clock),
        .reset    (reset),
        .clear    (vs_fall),
        .en       (pix_valid),
        .data     (pix_rgb),
        .crc_next (crc_next)
    );

    // Publish the finished frame checksum at each vs_fall
    always_ff @(posedge clock) begin
        if (reset) begin
            crc       <= '0;
            crc_valid <= 1'b0;
        end else begin
            crc_valid <= vs_fall;
            if (vs_fall)
                crc <= crc_next;
        end
    end
`else
    assign crc       = 16'h0000;
    assign crc_valid = 1'b0;
`endif

endmodule

// File: tb/tb_vga_rx.sv
// Self-checking bench for vga_rx on a reduced raster (8x4 active, 16x8 total)
// so that many whole frames fit in a short run.
module tb_vga_rx;

    localparam int HA = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HT = 16;
    localparam int VA = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VT = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        vga_hs = 1'b1;
    logic        vga_vs = 1'b1;
    logic        vga_blank_n = 1'b0;
    logic [7:0]  vga_r = 8'd0;
    logic [7:0]  vga_g = 8'd0;
    logic [7:0]  vga_b = 8'd0;
    logic        pix_valid;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic [23:0] pix_rgb;
    logic        frame_start;
    logic        locked;
    logic        err;
    logic [1:0]  err_code;
    logic [15:0] frame_count;
    logic [15:0] crc;
    logic        crc_valid;

    always #5 clock = ~clock;

    vga_rx #(
        .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_blank_n (vga_blank_n),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .pix_valid   (pix_valid),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_rgb     (pix_rgb),
        .frame_start (frame_start),
        .locked      (locked),
        .err         (err),
        .err_code    (err_code),
        .frame_count (frame_count),
        .crc         (crc),
        .crc_valid   (crc_valid)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor state, sampled on the falling clock edge
    int          err_total = 0;
    int          crc_total = 0;
    int          pix_total = 0;
    int          fs_total  = 0;
    logic [15:0] last_crc  = 16'h0;
    int          exp_x = 0;
    int          exp_y = 0;
    bit          pix_chk_en = 1'b0;
    logic        prev_locked = 1'b0;
    logic        prev_rst = 1'b1;

    task automatic monitor();
        logic [7:0] ex8;
        logic [7:0] ey8;
        if (err) begin
            err_total++;
            check("locked_low_during_err", 32'(locked), 32'd0);
        end
        if (prev_locked && !locked && !prev_rst)
            check("locked_fall_needs_err", 32'(err), 32'd1);
        if (crc_valid) begin
            crc_total++;
            last_crc = crc;
        end
        if (pix_chk_en && pix_valid) begin
            ex8 = 8'(exp_x);
            ey8 = 8'(exp_y);
            check("pix_x", 32'(pix_x), 32'(exp_x));
            check("pix_y", 32'(pix_y), 32'(exp_y));
            check("pix_rgb", 32'(pix_rgb), 32'({ex8, ey8, 8'h5A}));
            pix_total++;
            if (exp_x == HA - 1) begin
                exp_x = 0;
                exp_y = (exp_y == VA - 1) ? 0 : exp_y + 1;
            end else begin
                exp_x++;
            end
        end
        if (pix_chk_en && frame_start) begin
            fs_total++;
            check("frame_start_at_origin", 32'({pix_valid, pix_x, pix_y}), 32'h0010_0000);
        end
        prev_locked = locked;
        prev_rst    = reset;
    endtask

    // Drive one pixel clock of a raster at (line, col); hs/vs pulses sit after the active area
    task automatic drive_px(input int l, input int c, input int act_lines, input bit zero);
        vga_blank_n = (l < act_lines) && (c < HA);
        vga_hs      = !((c >= HA + HF) && (c < HA + HF + HS));
        vga_vs      = !((l >= VA + VF) && (l < VA + VF + VS));
        vga_r       = zero ? 8'd0 : 8'(c);
        vga_g       = zero ? 8'd0 : 8'(l);
        vga_b       = zero ? 8'd0 : 8'h5A;
        @(posedge clock);
        #1;
    endtask

    // One frame; short_ln drops the last back-porch clock of that line
    task automatic drive_frame(input int act_lines, input int n_lines, input int short_ln, input bit zero);
        for (int l = 0; l < n_lines; l++)
            for (int c = 0; c < HT; c++)
                if (!(l == short_ln && c == HT - 1))
                    drive_px(l, c, act_lines, zero);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pix"}, 32'({pix_valid, frame_start, pix_x, pix_y}), 32'd0);
        check({tag, "_rgb"}, 32'(pix_rgb), 32'd0);
        check({tag, "_status"}, 32'({locked, err, err_code, crc_valid}), 32'd0);
        check({tag, "_counts"}, {frame_count, crc}, 32'd0);
    endtask

    function automatic logic [15:0] crc_model(input logic [15:0] c_in, input logic [23:0] d);
        logic [15:0] c;
        logic        fb;
        c = c_in;
        for (int i = 23; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    typedef struct {
        int          act;
        int          lines;
        int          short_ln;
        int          exp_nerr;
        logic [1:0]  exp_code;
        logic        exp_lock;
        logic [15:0] exp_fc;
    } frame_vec_t;

    frame_vec_t tbl[13];

    initial begin
        int          e0;
        int          c0;
        logic [15:0] golden;
        logic [15:0] exp_crc;

        tbl[0]  = '{VA,     VT,     -1, 0, 2'd0, 1'b0, 16'd0};
        tbl[1]  = '{VA,     VT,     -1, 0, 2'd0, 1'b0, 16'd0};
        tbl[2]  = '{VA,     VT,     -1, 0, 2'd0, 1'b1, 16'd1};
        tbl[3]  = '{VA,     VT,     -1, 0, 2'd0, 1'b1, 16'd2};
        tbl[4]  = '{VA,     VT,      2, 1, 2'd1, 1'b0, 16'd2};
        tbl[5]  = '{VA,     VT,     -1, 0, 2'd1, 1'b0, 16'd2};
        tbl[6]  = '{VA,     VT,     -1, 0, 2'd1, 1'b1, 16'd3};
        tbl[7]  = '{VA,     VT - 1, -1, 0, 2'd1, 1'b1, 16'd4};
        tbl[8]  = '{VA,     VT,     -1, 1, 2'd2, 1'b0, 16'd4};
        tbl[9]  = '{VA,     VT,     -1, 0, 2'd2, 1'b0, 16'd4};
        tbl[10] = '{VA - 1, VT,     -1, 1, 2'd3, 1'b0, 16'd4};
        tbl[11] = '{VA,     VT,     -1, 0, 2'd3, 1'b0, 16'd4};
        tbl[12] = '{VA,     VT,     -1, 0, 2'd3, 1'b1, 16'd5};

        fork
            forever begin
                @(negedge clock);
                monitor();
            end
        join_none

        // Power-on reset
        reset = 1'b1;
        repeat (3) drive_px(VT - 1, HT - 1, VA, 1'b0);
        @(negedge clock);
        check_all_zero("reset");
        reset = 1'b0;

        // Frame table: lock acquisition, short line, short frame, short active area
        pix_chk_en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            e0 = err_total;
            drive_frame(tbl[i].act, tbl[i].lines, tbl[i].short_ln, 1'b0);
            check($sformatf("frame%0d_err_pulses", i), 32'(err_total - e0), 32'(tbl[i].exp_nerr));
            check($sformatf("frame%0d_err_code", i), 32'(err_code), 32'(tbl[i].exp_code));
            check($sformatf("frame%0d_locked", i), 32'(locked), 32'(tbl[i].exp_lock));
            check($sformatf("frame%0d_frame_count", i), 32'(frame_count), 32'(tbl[i].exp_fc));
            if (i == 3) begin
                pix_chk_en = 1'b0;
                check("sweep_pixel_total", 32'(pix_total), 32'(3 * HA * VA));
                check("sweep_frame_starts", 32'(fs_total), 32'd3);
            end
        end

        // Reset mid-line at (4,2) while locked
        for (int l = 0; l < 2; l++)
            for (int c = 0; c < HT; c++)
                drive_px(l, c, VA, 1'b0);
        for (int c = 0; c < 4; c++)
            drive_px(2, c, VA, 1'b0);
        reset = 1'b1;
        drive_px(2, 4, VA, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check_all_zero("midline_reset");
        e0 = err_total;
        for (int c = 5; c < HT; c++)
            drive_px(2, c, VA, 1'b0);
        for (int l = 3; l < VT; l++)
            for (int c = 0; c < HT; c++)
                drive_px(l, c, VA, 1'b0);
        drive_frame(VA, VT, -1, 1'b0);
        check("post_reset_no_err", 32'(err_total - e0), 32'd0);
        check("post_reset_not_locked", 32'(locked), 32'd0);
        drive_frame(VA, VT, -1, 1'b0);
        check("post_reset_relock", 32'({locked, frame_count}), 32'h0001_0001);
        check("post_reset_no_err_total", 32'(err_total - e0), 32'd0);

        // Per-frame CRC over all-zero frames
        golden = 16'hFFFF;
        for (int p = 0; p < HA * VA; p++)
            golden = crc_model(golden, 24'd0);
        reset = 1'b1;
        repeat (2) drive_px(VT - 1, HT - 1, VA, 1'b1);
        reset = 1'b0;
        for (int f = 0; f < 3; f++) begin
            c0 = crc_total;
            drive_frame(VA, VT, -1, 1'b1);
`ifdef VGA_RX_CRC_EN
            exp_crc = (f == 0) ? 16'hFFFF : golden;
            check($sformatf("crc_pulses_frame%0d", f), 32'(crc_total - c0), 32'd1);
            check($sformatf("crc_value_frame%0d", f), 32'(last_crc), 32'(exp_crc));
`else
            exp_crc = 16'h0000;
            check($sformatf("crc_pulses_frame%0d", f), 32'(crc_total - c0), 32'd0);
            check($sformatf("crc_tied_frame%0d", f), 32'(crc), 32'(exp_crc));
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
